ps_bigreg_collector: RTL

//  Generalised assembler for multi-word PS-written registers (seed, channel-mux, SDC class).
//  It sits between the AXI mem-map write path and RTL consumers.
//  It snoops WD_DATA_WIDTH-wide writes into NUM_REGS independent base..base+WORDS-1 windows.
//  A write to each window's valid ID (base+WORDS) commits the shadow words as one wide value.
//  The committed value is handed to the consumer over a valid/ready handshake, with a per-write AXI-style response.

---
 rtl/ps_bigreg_collector.sv | 138 +++++++++++++
 1 files changed

// File: rtl/ps_bigreg_collector.sv
// rtl/ps_bigreg_collector.sv - collects multi-word PS register writes and commits them as wide values
// Optional feature macro: PARTIAL_UPDATE_EN (commit even when some words were not rewritten).
module ps_bigreg_collector #(
  parameter int MEM_SIZE   = 256,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 3,
  parameter int MAX_WORDS  = 16,
  parameter int BASE_IDS [NUM_REGS] = '{1, 32, 35},
  parameter int WORDS    [NUM_REGS] = '{16, 2, 16},
  localparam int IDW = $clog2(MEM_SIZE),
  localparam int RW  = MAX_WORDS * DATA_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               wr_en,
  input  logic [IDW-1:0]                     wr_id,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  output logic                               resp_valid,
  output logic [1:0]                         resp,
  output logic [NUM_REGS-1:0][RW-1:0]        reg_data,
  output logic [NUM_REGS-1:0]                reg_valid,
  input  logic [NUM_REGS-1:0]                reg_ready,
  output logic [NUM_REGS-1:0][MAX_WORDS-1:0] fresh
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Each window spans base..base+WORDS inclusive (the last ID is the commit trigger).
  for (genvar a = 0; a < NUM_REGS; a++) begin : g_chk_a
    if (WORDS[a] < 1 || WORDS[a] > MAX_WORDS) begin : g_bad_words
      $error("ps_bigreg_collector: WORDS[%0d] out of range", a);
    end
    for (genvar b = a + 1; b < NUM_REGS; b++) begin : g_chk_b
      if (!((BASE_IDS[a] + WORDS[a] < BASE_IDS[b]) || (BASE_IDS[b] + WORDS[b] < BASE_IDS[a]))) begin : g_overlap
        $error("ps_bigreg_collector: windows %0d and %0d overlap", a, b);
      end
    end
  end

  logic [NUM_REGS-1:0] owned;
  logic [NUM_REGS-1:0] refused;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam logic [IDW-1:0]       BASE = IDW'(BASE_IDS[i]);
    localparam logic [IDW-1:0]       VID  = IDW'(BASE_IDS[i] + WORDS[i]);
    localparam logic [MAX_WORDS-1:0] MASK = {MAX_WORDS{1'b1}} >> (MAX_WORDS - WORDS[i]);

    typedef enum logic {IDLE, PENDING} state_e;
    state_e state_q, state_d;

    logic [MAX_WORDS-1:0][DATA_WIDTH-1:0] shadow_q;
    logic [MAX_WORDS-1:0][DATA_WIDTH-1:0] data_q;
    logic [MAX_WORDS-1:0]                 fresh_q;
    logic [MAX_WORDS-1:0]                 word_hit;
    logic                                 valid_hit;
    logic                                 allow;
    logic                                 commit;
    logic                                 err;
    logic                                 pending;

    always_comb begin
      word_hit = '0;
      for (int k = 0; k < MAX_WORDS; k++) begin
        if (k < WORDS[i]) word_hit[k] = wr_en && (wr_id == BASE + IDW'(k));
      end
      valid_hit = wr_en && (wr_id == VID);
`ifdef PARTIAL_UPDATE_EN
      allow = 1'b1;
`else
      allow = &(fresh_q | ~MASK);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
    end

    always_comb begin
      state_d = state_q;
      case (state_q)
        IDLE:    if (commit) state_d = PENDING;
        PENDING: if (commit) state_d = PENDING;
                 else if (reg_ready[i]) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // A busy register can only take a new commit in the cycle its consumer accepts.
    always_comb begin
      pending = (state_q == PENDING);
      commit  = valid_hit && allow && (!pending || reg_ready[i]);
      err     = valid_hit && !commit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shadow_q <= '0;
        data_q   <= '0;
        fresh_q  <= '0;
      end else begin
        for (int k = 0; k < MAX_WORDS; k++) begin
          if (word_hit[k]) shadow_q[k] <= wr_data;
        end
        if (commit) begin
          data_q  <= shadow_q;
          fresh_q <= '0;
        end else begin
          fresh_q <= fresh_q | word_hit;
        end
      end
    end

    assign reg_data[i]  = data_q;
    assign reg_valid[i] = pending;
    assign fresh[i]     = fresh_q & MASK;
    assign owned[i]     = (|word_hit) || valid_hit;
    assign refused[i]   = err;
  end

  logic       resp_valid_q;
  logic [1:0] resp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_q       <= RESP_OKAY;
    end else begin
      resp_valid_q <= |owned;
      resp_q       <= (|refused) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp       = resp_q;

endmodule
